pdp8_datapath_gen: RTL

- Parametrised next-generation PDP-8 CPU datapath: architectural registers AC, LK, MQ, PC, IR, EA, MB, plus memory address/write-data registers, all updated from a packed control word.
- Adds features the first-generation datapath lacked:
  - internal iterative EAE (MUY/DVI) with a valid/ready handshake
  - ISZ wrap flag
  - debounced switch-register change detection
- Sits between the controller FSM (drives ctrl_word) and memory/front panel.

---
 rtl/pdp8_dp_pkg.sv | 33 +++
 rtl/pdp8_eae_seq.sv | 96 +++++++++
 rtl/pdp8_datapath_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pdp8_dp_pkg.sv
// Shared control-word encoding and EAE state type for the next-generation PDP-8 datapath.
package pdp8_dp_pkg;

    localparam int AUTO_INDEX_BASE = 8;

    typedef enum logic [3:0] {
        AC_NC, AC_CLR, AC_AND, AC_TAD, AC_OR_DI, AC_OR_SR, AC_CMA, AC_RD, AC_MQ, AC_MUL, AC_DVI
    } ac_sel_t;

    typedef enum logic [1:0] {LK_NC, LK_CLR, LK_SET, LK_CML} lk_sel_t;
    typedef enum logic [1:0] {MQ_NC, MQ_CLR, MQ_AC} mq_sel_t;
    typedef enum logic [2:0] {PC_NC, PC_CLR, PC_INC, PC_EA, PC_SR} pc_sel_t;
    typedef enum logic       {IR_NC, IR_RD} ir_sel_t;
    typedef enum logic [2:0] {EA_NC, EA_PGE, EA_SMP, EA_RD, EA_MB} ea_sel_t;
    typedef enum logic [1:0] {MB_NC, MB_RD, MB_AC, MB_INC} mb_sel_t;
    typedef enum logic [1:0] {WD_NC, WD_AC, WD_MB, WD_PC} wd_sel_t;
    typedef enum logic [1:0] {AD_NC, AD_PC, AD_EA, AD_MB} ad_sel_t;

    typedef struct packed {
        ac_sel_t ac;
        lk_sel_t lk;
        mq_sel_t mq;
        pc_sel_t pc;
        ir_sel_t ir;
        ea_sel_t ea;
        mb_sel_t mb;
        wd_sel_t wd;
        ad_sel_t ad;
    } dp_ctrl_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV} eae_state_t;

endpackage

// File: rtl/pdp8_eae_seq.sv
// Iterative EAE engine: shift-add MUY and restoring DVI, one step per cycle.
// EAE_EARLY_TERM_EN lets MUY stop once the remaining multiplier bits are zero.
module pdp8_eae_seq
    import pdp8_dp_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             run,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] mb_in,
    output logic             done,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] mq_out,
    output logic             lk_out
);

    localparam int CW = $clog2(WIDTH);

    // acc holds the double-width product for MUY; its low half is the partial remainder for DVI.
    logic [2*WIDTH-1:0] acc, mcand, acc_step;
    logic [WIDTH-1:0]   lo, lo_step, rem_step;
    logic [WIDTH:0]     shifted, diff;
    logic [CW-1:0]      cnt;
    logic               is_div, ovf, last;

    always_comb begin
        acc_step = acc;
        lo_step  = lo >> 1;
        rem_step = acc[WIDTH-1:0];
        shifted  = {acc[WIDTH-1:0], lo[WIDTH-1]};
        diff     = shifted - {1'b0, mcand[WIDTH-1:0]};
        if (is_div) begin
            if (shifted >= {1'b0, mcand[WIDTH-1:0]}) begin
                rem_step = diff[WIDTH-1:0];
                lo_step  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                rem_step = shifted[WIDTH-1:0];
                lo_step  = {lo[WIDTH-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            acc_step = acc + mcand;
        end
`ifdef EAE_EARLY_TERM_EN
        last = is_div ? (ovf || cnt == CW'(WIDTH - 1)) : (lo[WIDTH-1:1] == '0);
`else
        last = ovf || cnt == CW'(WIDTH - 1);
`endif
        done = run && last;
        if (is_div && ovf) begin
            ac_out = acc[WIDTH-1:0];
            mq_out = lo;
            lk_out = 1'b1;
        end else if (is_div) begin
            ac_out = rem_step;
            mq_out = lo_step;
            lk_out = 1'b0;
        end else begin
            ac_out = acc_step[2*WIDTH-1:WIDTH];
            mq_out = acc_step[WIDTH-1:0];
            lk_out = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            acc    <= '0;
            mcand  <= '0;
            lo     <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            ovf    <= 1'b0;
        end else if (start_mul || start_div) begin
            acc    <= {{WIDTH{1'b0}}, ac_in};
            mcand  <= {{WIDTH{1'b0}}, mb_in};
            lo     <= mq_in;
            cnt    <= '0;
            is_div <= start_div;
            ovf    <= start_div && (ac_in >= mb_in);
        end else if (run) begin
            cnt <= cnt + CW'(1);
            lo  <= lo_step;
            if (is_div) begin
                acc[WIDTH-1:0] <= rem_step;
            end else begin
                acc   <= acc_step;
                mcand <= mcand << 1;
            end
        end
    end

endmodule

// File: rtl/pdp8_datapath_gen.sv
// Next-generation PDP-8 datapath: control-word register muxing, EAE handshake, ISZ wrap, switch debounce.
// Optional macro EAE_EARLY_TERM_EN shortens MUY latency to the multiplier's significant bits.
module pdp8_datapath_gen
    import pdp8_dp_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int PAGE_BITS   = 5,
    parameter int SR_DEBOUNCE = 4
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             op_valid,
    output logic             op_ready,
    input  dp_ctrl_t         ctrl_word,
    input  logic [WIDTH-1:0] read_data,
    input  logic [WIDTH-1:0] swreg,
    input  logic [7:0]       datain,
    output logic [WIDTH-1:0] ac,
    output logic [WIDTH-1:0] mq,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] ea,
    output logic [WIDTH-1:0] mb,
    output logic             lk,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] write_data,
    output logic             ea_in_auto,
    output logic             mb_wrap,
    output logic             eae_done,
    output logic             srchange
);

    localparam int DW = $clog2(SR_DEBOUNCE + 1);

    eae_state_t       state_q, state_d;
    logic             accept, is_eae, start_mul, start_div, run;
    logic             eng_done, eng_lk, tad_cout, lk_next;
    logic [WIDTH-1:0] eng_ac, eng_mq, tad_sum, mb_inc, ea_pge, ea_smp;
    logic [WIDTH-1:0] sr_ref, sr_cand;
    logic [DW-1:0]    sr_cnt, sr_cnt_next;

    assign op_ready   = (state_q == IDLE);
    assign accept     = op_valid && op_ready;
    assign is_eae     = (ctrl_word.ac == AC_MUL) || (ctrl_word.ac == AC_DVI);
    assign run        = (state_q != IDLE);
    assign ea_in_auto = (ea[WIDTH-1:3] == (WIDTH-3)'(AUTO_INDEX_BASE >> 3));
    assign {tad_cout, tad_sum} = {1'b0, ac} + {1'b0, mb};
    assign mb_inc     = mb + WIDTH'(1);
    assign ea_pge     = {pc[WIDTH-1:WIDTH-PAGE_BITS], ir[WIDTH-PAGE_BITS-1:0]};
    assign ea_smp     = {{PAGE_BITS{1'b0}}, ir[WIDTH-PAGE_BITS-1:0]};

    pdp8_eae_seq #(.WIDTH(WIDTH)) u_eae (
        .clock(clock), .resetN(resetN), .start_mul(start_mul), .start_div(start_div), .run(run),
        .ac_in(ac), .mq_in(mq), .mb_in(mb),
        .done(eng_done), .ac_out(eng_ac), .mq_out(eng_mq), .lk_out(eng_lk)
    );

    always_ff @(posedge clock) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        start_div = 1'b0;
        case (state_q)
            IDLE: if (accept && ctrl_word.ac == AC_MUL) begin
                state_d   = MUL;
                start_mul = 1'b1;
            end else if (accept && ctrl_word.ac == AC_DVI) begin
                state_d   = DIV;
                start_div = 1'b1;
            end
            MUL, DIV: if (eng_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // TAD's carry toggles whatever the link select produced in the same op.
    always_comb begin
        lk_next = lk;
        case (ctrl_word.lk)
            LK_CLR:  lk_next = 1'b0;
            LK_SET:  lk_next = 1'b1;
            LK_CML:  lk_next = ~lk;
            default: lk_next = lk;
        endcase
        if (ctrl_word.ac == AC_TAD) lk_next = lk_next ^ tad_cout;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            ac <= '0; lk <= 1'b0; mq <= '0; pc <= '0; ir <= '0; ea <= '0; mb <= '0;
            address <= '0; write_data <= '0; mb_wrap <= 1'b0; eae_done <= 1'b0;
        end else begin
            eae_done <= 1'b0;
            if (eng_done) begin
                ac       <= eng_ac;
                mq       <= eng_mq;
                lk       <= eng_lk;
                eae_done <= 1'b1;
            end else if (accept) begin
                mb_wrap <= 1'b0;
                if (!is_eae) begin
                    case (ctrl_word.ac)
                        AC_CLR:   ac <= '0;
                        AC_AND:   ac <= ac & mb;
                        AC_TAD:   ac <= tad_sum;
                        AC_OR_DI: ac <= ac | WIDTH'(datain);
                        AC_OR_SR: ac <= ac | swreg;
                        AC_CMA:   ac <= ~ac;
                        AC_RD:    ac <= read_data;
                        AC_MQ:    ac <= mq;
                        default:  ;
                    endcase
                    lk <= lk_next;
                    case (ctrl_word.mq)
                        MQ_CLR:  mq <= '0;
                        MQ_AC:   mq <= ac;
                        default: ;
                    endcase
                    case (ctrl_word.pc)
                        PC_CLR:  pc <= '0;
                        PC_INC:  pc <= pc + WIDTH'(1);
                        PC_EA:   pc <= ea;
                        PC_SR:   pc <= swreg;
                        default: ;
                    endcase
                    if (ctrl_word.ir == IR_RD) ir <= read_data;
                    case (ctrl_word.ea)
                        EA_PGE:  ea <= ea_pge;
                        EA_SMP:  ea <= ea_smp;
                        EA_RD:   ea <= read_data;
                        EA_MB:   ea <= mb;
                        default: ;
                    endcase
                    case (ctrl_word.mb)
                        MB_RD:   mb <= read_data;
                        MB_AC:   mb <= ac;
                        MB_INC: begin
                            mb      <= mb_inc;
                            mb_wrap <= (mb_inc == '0);
                        end
                        default: ;
                    endcase
                    case (ctrl_word.wd)
                        WD_AC:   write_data <= ac;
                        WD_MB:   write_data <= mb;
                        WD_PC:   write_data <= pc;
                        default: ;
                    endcase
                    case (ctrl_word.ad)
                        AD_PC:   address <= pc;
                        AD_EA:   address <= ea;
                        AD_MB:   address <= mb;
                        default: ;
                    endcase
                end
            end
        end
    end

    // A new switch value restarts the count; only a stable value differing from the reference pulses.
    always_comb begin
        if (swreg != sr_cand)                     sr_cnt_next = DW'(1);
        else if (sr_cnt == DW'(SR_DEBOUNCE))      sr_cnt_next = sr_cnt;
        else                                      sr_cnt_next = sr_cnt + DW'(1);
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            sr_ref   <= '0;
            sr_cand  <= '0;
            sr_cnt   <= '0;
            srchange <= 1'b0;
        end else begin
            sr_cand  <= swreg;
            sr_cnt   <= sr_cnt_next;
            srchange <= 1'b0;
            if (swreg != sr_ref && sr_cnt_next == DW'(SR_DEBOUNCE)) begin
                sr_ref   <= swreg;
                srchange <= 1'b1;
            end
        end
    end

endmodule
